// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between an instruction
// port and a data port: one access every two cycles, with per-port stall counters.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int NB_COL     = 4,
    parameter int COL_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [ADDR_WIDTH-1:0]         i_addr,
    output logic                          i_ack,
    output logic [NB_COL*COL_WIDTH-1:0]   i_rdata,
    input  logic                          d_req,
    input  logic [NB_COL-1:0]             d_wbe,
    input  logic [ADDR_WIDTH-1:0]         d_addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   d_wdata,
    output logic                          d_ack,
    output logic [NB_COL*COL_WIDTH-1:0]   d_rdata,
    output logic                          mem_ce,
    output logic [NB_COL-1:0]             mem_wbe,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [NB_COL*COL_WIDTH-1:0]   mem_data_in,
    input  logic [NB_COL*COL_WIDTH-1:0]   mem_data_out,
    output logic [CNT_WIDTH-1:0]          i_stall_cnt,
    output logic [CNT_WIDTH-1:0]          d_stall_cnt
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state_q;
    logic                 grant_data_q;
    logic                 last_data_q;
    logic [CNT_WIDTH-1:0] i_stall_q, i_stall_d;
    logic [CNT_WIDTH-1:0] d_stall_q, d_stall_d;
    logic                 idle;
    logic                 grant_any;
    logic                 grant_data;

    assign idle       = (state_q == IDLE);
    // On a tie the port that was not served last wins; a lone requester always wins.
    assign grant_data = d_req & (~i_req | ~last_data_q);
    // NOTE: the grant is combinational, so it is masked by rst to keep the memory quiet during reset.
    assign grant_any  = idle & ~rst & (i_req | d_req);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            grant_data_q <= 1'b0;
            last_data_q  <= 1'b0;
        end else if (idle) begin
            if (grant_any) begin
                state_q      <= RESP;
                grant_data_q <= grant_data;
                last_data_q  <= grant_data;
            end
        end else begin
            state_q <= IDLE;
        end
    end

    assign i_ack   = ~idle & ~grant_data_q;
    assign d_ack   = ~idle &  grant_data_q;
    assign i_rdata = mem_data_out;
    assign d_rdata = mem_data_out;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        mem_ce      = 1'b0;
        mem_wbe     = '0;
        mem_address = '0;
        mem_data_in = '0;
        if (grant_any) begin
            mem_ce = 1'b1;
            if (grant_data) begin
                mem_address = d_addr;
                mem_wbe     = d_wbe;
                mem_data_in = d_wdata;
            end else begin
                mem_address = i_addr;
            end
        end
    end

    // A stall is a cycle spent losing arbitration in IDLE; waiting out the
    // other port's RESP cycle is not counted.
    always_comb begin
        i_stall_d = i_stall_q;
        d_stall_d = d_stall_q;
        if (grant_any && i_req && grant_data && (i_stall_q != '1)) begin
            i_stall_d = i_stall_q + 1'b1;
        end
        if (grant_any && d_req && !grant_data && (d_stall_q != '1)) begin
            d_stall_d = d_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_stall_q <= '0;
            d_stall_q <= '0;
        end else begin
            i_stall_q <= i_stall_d;
            d_stall_q <= d_stall_d;
        end
    end

    assign i_stall_cnt = i_stall_q;
    assign d_stall_cnt = d_stall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus sequences
// for continuous round-robin, reset during RESP and stall-counter saturation.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [9:0]  i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_wbe;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_ce;
    logic [3:0]  mem_wbe;
    logic [9:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic [15:0] i_stall_cnt;
    logic [15:0] d_stall_cnt;

    // Second instance with narrow counters so saturation is reachable quickly.
    logic        s_i_req;
    logic        s_d_req;
    logic        s_i_ack;
    logic        s_d_ack;
    logic [31:0] s_i_rdata;
    logic [31:0] s_d_rdata;
    logic        s_mem_ce;
    logic [3:0]  s_mem_wbe;
    logic [9:0]  s_mem_address;
    logic [31:0] s_mem_data_in;
    logic [31:0] s_mem_data_out;
    logic [3:0]  s_i_stall_cnt;
    logic [3:0]  s_d_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_wbe        (d_wbe),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .mem_ce       (mem_ce),
        .mem_wbe      (mem_wbe),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .i_stall_cnt  (i_stall_cnt),
        .d_stall_cnt  (d_stall_cnt)
    );

    mem_arbiter #(.CNT_WIDTH(4)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .i_req        (s_i_req),
        .i_addr       (10'h001),
        .i_ack        (s_i_ack),
        .i_rdata      (s_i_rdata),
        .d_req        (s_d_req),
        .d_wbe        (4'b0000),
        .d_addr       (10'h002),
        .d_wdata      (32'h0),
        .d_ack        (s_d_ack),
        .d_rdata      (s_d_rdata),
        .mem_ce       (s_mem_ce),
        .mem_wbe      (s_mem_wbe),
        .mem_address  (s_mem_address),
        .mem_data_in  (s_mem_data_in),
        .mem_data_out (s_mem_data_out),
        .i_stall_cnt  (s_i_stall_cnt),
        .d_stall_cnt  (s_d_stall_cnt)
    );

    assign s_mem_data_out = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory model: byte-enabled writes, registered read, loaded on the first edge.
    logic [31:0] mem [0:1023];
    bit          mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 1024; a++) begin
                mem[a] <= (a == 32'h20) ? 32'h11223344 : (32'hC0DE0000 | 32'(a));
            end
            mem_ready <= 1'b1;
        end else if (mem_ce) begin
            mem_data_out <= mem[mem_address];
            for (int b = 0; b < 4; b++) begin
                if (mem_wbe[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        i_req;
        logic [9:0]  i_addr;
        logic        d_req;
        logic [3:0]  d_wbe;
        logic [9:0]  d_addr;
        logic [31:0] d_wdata;
        logic        ce;
        logic [3:0]  wbe;
        logic [9:0]  addr;
        logic [31:0] din;
        logic        i_ack;
        logic        d_ack;
        logic        chk_rd;
        logic [31:0] rdata;
        logic [15:0] d_stall;
    } vec_t;

    vec_t vecs [16];

    initial begin
        // inputs: i_req i_addr d_req d_wbe d_addr d_wdata | expected: ce wbe addr din i_ack d_ack chk_rd rdata d_stall
        vecs[0]  = '{1'b0, 10'h000, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[1]  = '{1'b1, 10'h010, 1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 4'h0, 10'h010, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[2]  = '{1'b1, 10'h010, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC0DE0010, 16'd0};
        vecs[3]  = '{1'b0, 10'h000, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[4]  = '{1'b0, 10'h000, 1'b1, 4'h3, 10'h020, 32'hAABBCCDD, 1'b1, 4'h3, 10'h020, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[5]  = '{1'b0, 10'h000, 1'b1, 4'h3, 10'h020, 32'hAABBCCDD, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        16'd0};
        vecs[6]  = '{1'b0, 10'h000, 1'b1, 4'h0, 10'h020, 32'h0,        1'b1, 4'h0, 10'h020, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[7]  = '{1'b0, 10'h000, 1'b1, 4'h0, 10'h020, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h1122CCDD, 16'd0};
        vecs[8]  = '{1'b1, 10'h030, 1'b1, 4'hF, 10'h040, 32'h12345678, 1'b1, 4'h0, 10'h030, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd0};
        vecs[9]  = '{1'b1, 10'h030, 1'b1, 4'hF, 10'h040, 32'h12345678, 1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC0DE0030, 16'd1};
        vecs[10] = '{1'b0, 10'h000, 1'b1, 4'hF, 10'h040, 32'h12345678, 1'b1, 4'hF, 10'h040, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0,        16'd1};
        vecs[11] = '{1'b0, 10'h000, 1'b1, 4'hF, 10'h040, 32'h12345678, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        16'd1};
        vecs[12] = '{1'b1, 10'h040, 1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 4'h0, 10'h040, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd1};
        vecs[13] = '{1'b1, 10'h040, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b1, 32'h12345678, 16'd1};
        vecs[14] = '{1'b1, 10'h050, 1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 4'h0, 10'h050, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        16'd1};
        vecs[15] = '{1'b0, 10'h000, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 1'b0, 1'b1, 32'hC0DE0050, 16'd1};

        rst = 1'b1; i_req = 1'b1; i_addr = 10'h010;
        d_req = 1'b0; d_wbe = 4'h0; d_addr = 10'h000; d_wdata = 32'h0;
        s_i_req = 1'b0; s_d_req = 1'b0;

        // Reset state, with a request present that must not reach the memory.
        repeat (2) @(posedge clk);
        #5;
        check("rst mem_ce", {31'h0, mem_ce}, 32'h0);
        check("rst mem_address", {22'h0, mem_address}, 32'h0);
        check("rst i_ack", {31'h0, i_ack}, 32'h0);
        check("rst d_ack", {31'h0, d_ack}, 32'h0);
        check("rst i_stall", {16'h0, i_stall_cnt}, 32'h0);
        check("rst d_stall", {16'h0, d_stall_cnt}, 32'h0);
        rst = 1'b0; i_req = 1'b0; i_addr = 10'h000;

        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #2;
            i_req = vecs[k].i_req; i_addr = vecs[k].i_addr;
            d_req = vecs[k].d_req; d_wbe = vecs[k].d_wbe;
            d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
            #3;
            check($sformatf("v%0d mem_ce", k), {31'h0, mem_ce}, {31'h0, vecs[k].ce});
            check($sformatf("v%0d mem_wbe", k), {28'h0, mem_wbe}, {28'h0, vecs[k].wbe});
            check($sformatf("v%0d mem_address", k), {22'h0, mem_address}, {22'h0, vecs[k].addr});
            check($sformatf("v%0d mem_data_in", k), mem_data_in, vecs[k].din);
            check($sformatf("v%0d i_ack", k), {31'h0, i_ack}, {31'h0, vecs[k].i_ack});
            check($sformatf("v%0d d_ack", k), {31'h0, d_ack}, {31'h0, vecs[k].d_ack});
            check($sformatf("v%0d i_stall", k), {16'h0, i_stall_cnt}, 32'h0);
            check($sformatf("v%0d d_stall", k), {16'h0, d_stall_cnt}, {16'h0, vecs[k].d_stall});
            if (vecs[k].chk_rd) begin
                if (vecs[k].i_ack) check($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].rdata);
                else               check($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].rdata);
            end
        end

        // Both ports requesting continuously from reset: D, I, D, I with acks every two cycles.
        @(posedge clk);
        #2;
        rst = 1'b1;
        i_req = 1'b1; i_addr = 10'h011;
        d_req = 1'b1; d_wbe = 4'h0; d_addr = 10'h012; d_wdata = 32'h0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #3;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #5;
            end
            case (k % 4)
                0: begin
                    check($sformatf("rr%0d mem_ce", k), {31'h0, mem_ce}, 32'h1);
                    check($sformatf("rr%0d mem_address", k), {22'h0, mem_address}, 32'h012);
                    check($sformatf("rr%0d d_ack", k), {31'h0, d_ack}, 32'h0);
                end
                1: begin
                    check($sformatf("rr%0d mem_ce", k), {31'h0, mem_ce}, 32'h0);
                    check($sformatf("rr%0d d_ack", k), {31'h0, d_ack}, 32'h1);
                    check($sformatf("rr%0d d_rdata", k), d_rdata, 32'hC0DE0012);
                end
                2: begin
                    check($sformatf("rr%0d mem_ce", k), {31'h0, mem_ce}, 32'h1);
                    check($sformatf("rr%0d mem_address", k), {22'h0, mem_address}, 32'h011);
                    check($sformatf("rr%0d i_ack", k), {31'h0, i_ack}, 32'h0);
                end
                default: begin
                    check($sformatf("rr%0d mem_ce", k), {31'h0, mem_ce}, 32'h0);
                    check($sformatf("rr%0d i_ack", k), {31'h0, i_ack}, 32'h1);
                    check($sformatf("rr%0d i_rdata", k), i_rdata, 32'hC0DE0011);
                end
            endcase
            check($sformatf("rr%0d ack exclusive", k), {31'h0, i_ack & d_ack}, 32'h0);
        end
        @(posedge clk);
        #5;
        check("rr i_stall after 8", {16'h0, i_stall_cnt}, 32'd2);
        check("rr d_stall after 8", {16'h0, d_stall_cnt}, 32'd2);
        i_req = 1'b0; d_req = 1'b0;

        // Reset during the RESP of a data read aborts the ack; the held request is re-granted.
        repeat (2) @(posedge clk);
        #2;
        d_req = 1'b1; d_addr = 10'h020; d_wbe = 4'h0; d_wdata = 32'h0;
        #3;
        check("rstresp grant mem_ce", {31'h0, mem_ce}, 32'h1);
        @(posedge clk);
        #5;
        check("rstresp d_ack before rst", {31'h0, d_ack}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("rstresp d_ack in rst", {31'h0, d_ack}, 32'h0);
        check("rstresp mem_ce in rst", {31'h0, mem_ce}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #3;
        check("rstresp regrant mem_ce", {31'h0, mem_ce}, 32'h1);
        check("rstresp regrant address", {22'h0, mem_address}, 32'h020);
        check("rstresp regrant d_ack", {31'h0, d_ack}, 32'h0);
        @(posedge clk);
        #5;
        check("rstresp d_ack after", {31'h0, d_ack}, 32'h1);
        check("rstresp d_rdata", d_rdata, 32'h1122CCDD);
        d_req = 1'b0;

        // Stall counters saturate at all-ones instead of wrapping.
        @(posedge clk);
        #2;
        s_i_req = 1'b1; s_d_req = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #5;
            check($sformatf("sat%0d ack exclusive", k), {31'h0, s_i_ack & s_d_ack}, 32'h0);
            if (k == 7) begin
                check("sat i_stall after 8", {28'h0, s_i_stall_cnt}, 32'd2);
                check("sat d_stall after 8", {28'h0, s_d_stall_cnt}, 32'd2);
            end
        end
        check("sat i_stall held", {28'h0, s_i_stall_cnt}, 32'hF);
        check("sat d_stall held", {28'h0, s_d_stall_cnt}, 32'hF);
        s_i_req = 1'b0; s_d_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
